// File: rtl/rail_fence_pkg.sv
// Shared definitions for the rail-fence encryptor/decryptor pair.
package rail_fence_pkg;

    localparam logic [7:0] TERM_DEFAULT = 8'hFA;

    localparam logic [1:0] KEY_1R = 2'b01;
    localparam logic [1:0] KEY_2R = 2'b10;
    localparam logic [1:0] KEY_3R = 2'b11;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    // Decode a key into a rail count; unused encodings fall back to one rail.
    function automatic logic [1:0] rail_count(input logic [1:0] k);
        case (k)
            KEY_1R:  return 2'd1;
            KEY_2R:  return 2'd2;
            KEY_3R:  return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/rail_index_gen.sv
// Combinational zigzag walker: given the current rail and buffer index,
// produces the next index to read, skipping rails that are empty for this length.
module rail_index_gen #(
    parameter int unsigned IW = 6
) (
    input  logic [1:0]    rails,
    input  logic [1:0]    r,
    input  logic [IW-1:0] idx,
    input  logic [IW-1:0] len,
    output logic [IW-1:0] next_idx,
    output logic [1:0]    next_r,
    output logic          last
);
    // Extra headroom so idx + 4 never wraps even for tiny buffers.
    localparam int unsigned EW = IW + 3;

    logic [EW-1:0] step;
    logic [EW-1:0] cand;
    logic [EW-1:0] nr_ext;

    // Rail r starts at index r, so a rail is non-empty exactly when r < len.
    always_comb begin
        step = EW'(1);
        if (rails == 2'd2)
            step = EW'(2);
        else if (rails == 2'd3)
            step = (r == 2'd1) ? EW'(2) : EW'(4);

        cand     = EW'(idx) + step;
        nr_ext   = EW'(r) + EW'(1);
        next_idx = idx;
        next_r   = r;
        last     = 1'b0;

        if (cand < EW'(len)) begin
            next_idx = cand[IW-1:0];
        end else if ((nr_ext < EW'(rails)) && (nr_ext < EW'(len))) begin
            next_r   = nr_ext[1:0];
            next_idx = nr_ext[IW-1:0];
        end else begin
            last = 1'b1;
        end
    end

endmodule

// File: rtl/rail_fence_encrypt.sv
// Streaming rail-fence encryptor: buffers plaintext up to TERM (or MAX_LEN bytes),
// then emits ciphertext rail by rail followed by TERM.
// Optional port busy is present when RAIL_ENC_BUSY_EN is defined.
module rail_fence_encrypt
    import rail_fence_pkg::*;
#(
    parameter int unsigned MAX_LEN = 32,
    parameter logic [7:0]  TERM    = TERM_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic [1:0] key,
    output logic [7:0] data_e,
    output logic       valid_e
`ifdef RAIL_ENC_BUSY_EN
    ,
    output logic       busy
`endif
);
    localparam int unsigned   IW      = $clog2(MAX_LEN + 1);
    localparam int unsigned   AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [IW-1:0] LEN_MAX = IW'(MAX_LEN);

    state_t        state, state_n;
    logic [IW-1:0] len, len_n;
    logic [IW-1:0] idx, idx_n;
    logic [1:0]    r, r_n;
    logic [1:0]    key_q, key_n;
    logic [7:0]    data_e_n;
    logic          valid_e_n;
    logic          wr_en;
    logic          accept;
    logic [1:0]    rails;
    logic [IW-1:0] gen_idx;
    logic [1:0]    gen_r;
    logic          gen_last;
    logic [7:0]    mem [MAX_LEN];

    assign rails = rail_count(key_q);

    rail_index_gen #(.IW(IW)) u_index_gen (
        .rails    (rails),
        .r        (r),
        .idx      (idx),
        .len      (len),
        .next_idx (gen_idx),
        .next_r   (gen_r),
        .last     (gen_last)
    );

    // Next-state and output decode; the TERM output cycle is the one where idx has run past len.
    always_comb begin
        state_n   = state;
        len_n     = len;
        idx_n     = idx;
        r_n       = r;
        key_n     = key_q;
        data_e_n  = data_e;
        valid_e_n = 1'b0;
        wr_en     = 1'b0;
        accept    = 1'b0;

        case (state)
            COLLECT: begin
                accept = (data != TERM) && (len < LEN_MAX);
                if (accept) begin
                    wr_en = 1'b1;
                    len_n = len + IW'(1);
                    if (len == '0)
                        key_n = key;
                end
                if ((data == TERM) && (len == '0))
                    key_n = key;
                if ((data == TERM) || (len == LEN_MAX) || (accept && (len_n == LEN_MAX))) begin
                    state_n = EMIT;
                    r_n     = '0;
                    idx_n   = '0;
                end
            end
            EMIT: begin
                valid_e_n = 1'b1;
                if (idx < len) begin
                    data_e_n = mem[idx[AW-1:0]];
                    idx_n    = gen_last ? len : gen_idx;
                    r_n      = gen_r;
                end else begin
                    data_e_n = TERM;
                    len_n    = '0;
                    state_n  = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= COLLECT;
        else
            state <= state_n;
    end

    // Counters, latched key and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            len     <= '0;
            idx     <= '0;
            r       <= '0;
            key_q   <= '0;
            data_e  <= '0;
            valid_e <= 1'b0;
        end else begin
            len     <= len_n;
            idx     <= idx_n;
            r       <= r_n;
            key_q   <= key_n;
            data_e  <= data_e_n;
            valid_e <= valid_e_n;
        end
    end

    // Plaintext buffer; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[len[AW-1:0]] <= data;
    end

`ifdef RAIL_ENC_BUSY_EN
    logic busy_n;

    // Stay high through the TERM output cycle, which is already back in COLLECT.
    assign busy_n = (state == EMIT) || (state_n == EMIT);

    // Registered busy flag.
    always_ff @(posedge clk) begin
        if (reset)
            busy <= 1'b0;
        else
            busy <= busy_n;
    end
`endif

endmodule

// File: tb/tb_rail_fence_encrypt.sv
// Directed self-checking bench for rail_fence_encrypt (default and MAX_LEN=4 instances).
module tb_rail_fence_encrypt;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_a, data_b;
    logic [1:0] key_a, key_b;
    logic [7:0] data_e_a, data_e_b;
    logic       valid_e_a, valid_e_b;
`ifdef RAIL_ENC_BUSY_EN
    logic       busy_a, busy_b;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    rail_fence_encrypt #(.MAX_LEN(32), .TERM(8'hFA)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .data    (data_a),
        .key     (key_a),
        .data_e  (data_e_a),
        .valid_e (valid_e_a)
`ifdef RAIL_ENC_BUSY_EN
        ,
        .busy    (busy_a)
`endif
    );

    rail_fence_encrypt #(.MAX_LEN(4), .TERM(8'hFA)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .data    (data_b),
        .key     (key_b),
        .data_e  (data_e_b),
        .valid_e (valid_e_b)
`ifdef RAIL_ENC_BUSY_EN
        ,
        .busy    (busy_b)
`endif
    );

    task automatic step_a(input logic [7:0] b);
        data_a = b;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic [7:0] b);
        data_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step_a(8'h41);
        step_a(8'h42);
        compared++;
        if ({valid_e_a, data_e_a} !== 9'h000) begin
            mismatched++;
            $display("FAIL reset_a: got valid=%b data=%h, expected valid=0 data=00", valid_e_a, data_e_a);
        end
        compared++;
        if ({valid_e_b, data_e_b} !== 9'h000) begin
            mismatched++;
            $display("FAIL reset_b: got valid=%b data=%h, expected valid=0 data=00", valid_e_b, data_e_b);
        end
`ifdef RAIL_ENC_BUSY_EN
        compared++;
        if (busy_a !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_busy: got %b, expected 0", busy_a);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_two_rails();
        logic [7:0] din [10];
        logic [7:0] exp [10];
        din = '{8'h44, 8'h45, 8'h43, 8'h52, 8'h49, 8'h50, 8'h54, 8'h41, 8'h54, 8'hFA};
        exp = '{8'h44, 8'h43, 8'h49, 8'h54, 8'h54, 8'h45, 8'h52, 8'h50, 8'h41, 8'hFA};
        pulse_reset();
        key_a = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step_a(din[i]);
            compared++;
            if (valid_e_a !== 1'b0) begin
                mismatched++;
                $display("FAIL two_rails_collect[%0d]: got valid=%b, expected 0", i, valid_e_a);
            end
        end
        for (int j = 0; j < 10; j++) begin
            step_a(8'h55);
            compared++;
            if ({valid_e_a, data_e_a} !== {1'b1, exp[j]}) begin
                mismatched++;
                $display("FAIL two_rails[%0d]: got valid=%b data=%h, expected valid=1 data=%h", j, valid_e_a, data_e_a, exp[j]);
            end
`ifdef RAIL_ENC_BUSY_EN
            compared++;
            if (busy_a !== 1'b1) begin
                mismatched++;
                $display("FAIL two_rails_busy[%0d]: got %b, expected 1", j, busy_a);
            end
`endif
        end
    endtask

    task automatic test_three_rails();
        logic [7:0] din [8];
        logic [7:0] exp [8];
        din = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'hFA};
        exp = '{8'h41, 8'h45, 8'h42, 8'h44, 8'h46, 8'h43, 8'h47, 8'hFA};
        pulse_reset();
        key_a = 2'b11;
        for (int i = 0; i < 8; i++) step_a(din[i]);
        for (int j = 0; j < 8; j++) begin
            step_a(8'h55);
            compared++;
            if ({valid_e_a, data_e_a} !== {1'b1, exp[j]}) begin
                mismatched++;
                $display("FAIL three_rails[%0d]: got valid=%b data=%h, expected valid=1 data=%h", j, valid_e_a, data_e_a, exp[j]);
            end
        end
        step_a(8'hFA);
        compared++;
        if (valid_e_a !== 1'b0) begin
            mismatched++;
            $display("FAIL three_rails_after: got valid=%b, expected 0", valid_e_a);
        end
    endtask

    task automatic test_edge_cases();
        logic [7:0] din [4];
        logic [7:0] exp [4];
        // One rail: ciphertext equals plaintext.
        din = '{8'h31, 8'h32, 8'h33, 8'hFA};
        exp = '{8'h31, 8'h32, 8'h33, 8'hFA};
        pulse_reset();
        key_a = 2'b01;
        for (int i = 0; i < 4; i++) step_a(din[i]);
        for (int j = 0; j < 4; j++) begin
            step_a(8'h55);
            compared++;
            if ({valid_e_a, data_e_a} !== {1'b1, exp[j]}) begin
                mismatched++;
                $display("FAIL one_rail[%0d]: got valid=%b data=%h, expected valid=1 data=%h", j, valid_e_a, data_e_a, exp[j]);
            end
        end
        // Empty message: only TERM comes out, one cycle after the EMIT entry edge.
        pulse_reset();
        key_a = 2'b11;
        step_a(8'hFA);
        compared++;
        if (valid_e_a !== 1'b0) begin
            mismatched++;
            $display("FAIL empty_latency: got valid=%b, expected 0", valid_e_a);
        end
        step_a(8'h55);
        compared++;
        if ({valid_e_a, data_e_a} !== 9'h1FA) begin
            mismatched++;
            $display("FAIL empty_term: got valid=%b data=%h, expected valid=1 data=fa", valid_e_a, data_e_a);
        end
        // Three rails, one byte: rails 1 and 2 empty and skipped.
        pulse_reset();
        step_a(8'h41);
        step_a(8'hFA);
        step_a(8'h55);
        compared++;
        if ({valid_e_a, data_e_a} !== 9'h141) begin
            mismatched++;
            $display("FAIL short_byte: got valid=%b data=%h, expected valid=1 data=41", valid_e_a, data_e_a);
        end
        step_a(8'h55);
        compared++;
        if ({valid_e_a, data_e_a} !== 9'h1FA) begin
            mismatched++;
            $display("FAIL short_term: got valid=%b data=%h, expected valid=1 data=fa", valid_e_a, data_e_a);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] din [9];
        logic [9:0] exp [9];
        din = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'hFA, 8'hFA, 8'hFA};
        // {compare-enable, valid, data} per edge: four collect edges then len+1 outputs.
        exp = '{10'h200, 10'h200, 10'h200, 10'h200,
                10'h361, 10'h363, 10'h362, 10'h364, 10'h3FA};
        pulse_reset();
        key_b = 2'b10;
        for (int i = 0; i < 9; i++) begin
            step_b(din[i]);
            compared++;
            if ({valid_e_b, (exp[i][8] ? data_e_b : 8'h00)} !== exp[i][8:0]) begin
                mismatched++;
                $display("FAIL overflow[%0d]: got valid=%b data=%h, expected valid=%b data=%h", i, valid_e_b, data_e_b, exp[i][8], exp[i][7:0]);
            end
        end
        data_b = 8'hFA;
    endtask

    task automatic test_reset_mid_emit();
        logic [7:0] din [5];
        logic [7:0] exp [3];
        din = '{8'h41, 8'h42, 8'h43, 8'h44, 8'hFA};
        pulse_reset();
        key_a = 2'b10;
        for (int i = 0; i < 5; i++) step_a(din[i]);
        step_a(8'h55);
        step_a(8'h55);
        compared++;
        if ({valid_e_a, data_e_a} !== 9'h143) begin
            mismatched++;
            $display("FAIL pre_abort: got valid=%b data=%h, expected valid=1 data=43", valid_e_a, data_e_a);
        end
        reset = 1'b1;
        step_a(8'h55);
        reset = 1'b0;
        compared++;
        if ({valid_e_a, data_e_a} !== 9'h000) begin
            mismatched++;
            $display("FAIL abort: got valid=%b data=%h, expected valid=0 data=00", valid_e_a, data_e_a);
        end
        din = '{8'h41, 8'h42, 8'hFA, 8'h00, 8'h00};
        exp = '{8'h41, 8'h42, 8'hFA};
        for (int i = 0; i < 3; i++) step_a(din[i]);
        for (int j = 0; j < 3; j++) begin
            step_a(8'h55);
            compared++;
            if ({valid_e_a, data_e_a} !== {1'b1, exp[j]}) begin
                mismatched++;
                $display("FAIL after_abort[%0d]: got valid=%b data=%h, expected valid=1 data=%h", j, valid_e_a, data_e_a, exp[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m1 [6];
        logic [7:0] e1 [6];
        logic [7:0] m2 [4];
        logic [7:0] e2 [4];
        m1 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'hFA};
        e1 = '{8'h41, 8'h45, 8'h42, 8'h44, 8'h43, 8'hFA};
        m2 = '{8'h31, 8'h32, 8'h33, 8'hFA};
        e2 = '{8'h31, 8'h33, 8'h32, 8'hFA};
        pulse_reset();
        key_a = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step_a(m1[i]);
            key_a = 2'b01;
        end
        for (int j = 0; j < 6; j++) begin
            step_a(8'h55);
            compared++;
            if ({valid_e_a, data_e_a} !== {1'b1, e1[j]}) begin
                mismatched++;
                $display("FAIL b2b_msg1[%0d]: got valid=%b data=%h, expected valid=1 data=%h", j, valid_e_a, data_e_a, e1[j]);
            end
        end
        // First byte of message 2 is presented during the TERM output cycle.
        key_a = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step_a(m2[i]);
            compared++;
            if (valid_e_a !== 1'b0) begin
                mismatched++;
                $display("FAIL b2b_collect[%0d]: got valid=%b, expected 0", i, valid_e_a);
            end
        end
        for (int j = 0; j < 4; j++) begin
            step_a(8'h55);
            compared++;
            if ({valid_e_a, data_e_a} !== {1'b1, e2[j]}) begin
                mismatched++;
                $display("FAIL b2b_msg2[%0d]: got valid=%b data=%h, expected valid=1 data=%h", j, valid_e_a, data_e_a, e2[j]);
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        data_a = 8'h00;
        data_b = 8'hFA;
        key_a  = 2'b00;
        key_b  = 2'b00;
        test_reset();
        test_two_rails();
        test_three_rails();
        test_edge_cases();
        test_overflow();
        test_reset_mid_emit();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
